// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central pipeline controller for the 5-stage MIPS core. Every cycle it
// decides whether the PC advances, whether IF/ID holds or is flushed to NOP,
// and whether a bubble goes into ID/EX. It detects load-use and
// branch-operand hazards, redirects on taken branches/jumps resolved in ID,
// absorbs instruction-memory wait states and sequences the multi-cycle
// mult/div unit (MDU). Saturating statistics counters track stalls and flushes.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   id_*                fields/flags of the instruction sitting in ID
//   ex_*                load/regwrite/destination of the instruction in EX
//   mem_*               load/destination of the instruction in MEM
//   imem_ready          instruction fetch completes this cycle
//   pc_we               PC write enable
//   ifid_hold           IF/ID keeps its contents
//   ifid_flush          IF/ID loads NOP
//   idex_bubble         ID/EX loads NOP / zero controls
//   mdu_start           one-cycle start pulse to the MDU
//   mdu_busy            MDU operation in progress
//   stall_cnt           saturating count of stall cycles
//   flush_cnt           saturating count of taken-branch flushes
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_branch,
    input  logic             id_bj_taken,
    input  logic             id_mdu_start,
    input  logic             id_mdu_read,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic [4:0]       ex_rd,
    input  logic             mem_memread,
    input  logic [4:0]       mem_rd,
    input  logic             imem_ready,
    output logic             pc_we,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             mdu_start,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int MW = $clog2(MDU_LAT);
    localparam logic [MW-1:0] MCNT_LOAD = MW'(MDU_LAT - 1);

    typedef enum logic {
        M_IDLE,
        M_BUSY
    } mstate_t;

    mstate_t          state_reg;
    logic [MW-1:0]    mcnt_reg;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;

    logic load_use;
    logic br_dep;
    logic mdu_dep;
    logic stall_id;
    logic redirect;

    // ------------------------------------------------------------------
    // Hazard detection; register 0 is never a real dependency.
    // ------------------------------------------------------------------
    logic ex_rd_nz;
    logic mem_rd_nz;

    assign ex_rd_nz  = (ex_rd != 5'd0);
    assign mem_rd_nz = (mem_rd != 5'd0);

    assign load_use = ex_memread & ex_rd_nz &
                      ((id_use_rs & (id_rs == ex_rd)) |
                       (id_use_rt & (id_rt == ex_rd)));

    // Branches compare operands in ID, so any not-yet-available producer
    // in EX (any regwrite) or a load still in MEM blocks them.
    assign br_dep = id_branch &
                    ((ex_regwrite & ex_rd_nz &
                      ((id_rs == ex_rd) | (id_rt == ex_rd))) |
                     (mem_memread & mem_rd_nz &
                      ((id_rs == mem_rd) | (id_rt == mem_rd))));

    assign mdu_busy = (state_reg == M_BUSY);
    assign mdu_dep  = mdu_busy & (id_mdu_start | id_mdu_read);
    assign stall_id = load_use | br_dep | mdu_dep;

    // A taken branch only redirects once its operands are valid.
    assign redirect = id_bj_taken & ~stall_id;

    // A stalled mult/div is simply retried later; while busy, mdu_dep
    // stalls it so a start can only escape from M_IDLE.
    assign mdu_start = id_mdu_start & ~stall_id & ~rst;

    // ------------------------------------------------------------------
    // Pipeline control, strict priority.
    // ------------------------------------------------------------------
    always_comb begin
        pc_we       = 1'b1;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (rst) begin
            pc_we       = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (stall_id) begin
            pc_we       = 1'b0;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
        end else if (id_bj_taken) begin
            // Redirect wins over a pending fetch; the in-flight fetch is dropped.
            pc_we      = 1'b1;
            ifid_flush = 1'b1;
        end else if (!imem_ready) begin
            pc_we      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // MDU sequencer: busy for exactly MDU_LAT cycles after the start cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= M_IDLE;
            mcnt_reg  <= '0;
        end else begin
            case (state_reg)
                M_IDLE: begin
                    if (mdu_start) begin
                        state_reg <= M_BUSY;
                        mcnt_reg  <= MCNT_LOAD;
                    end
                end
                M_BUSY: begin
                    if (mcnt_reg == '0) begin
                        state_reg <= M_IDLE;
                    end else begin
                        mcnt_reg <= mcnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= M_IDLE;
                    mcnt_reg  <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Saturating statistics counters.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (stall_id && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
            if (redirect && (flush_cnt_reg != '1)) begin
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Self-checking bench for pipe_hazard_ctrl (MDU_LAT=4, CNT_W=4). A reference
// model built from the hazard rules, an MDU "cycles remaining" count and
// plain saturating integers predicts every output each cycle. Directed
// scenarios are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int LAT  = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs, id_rt, ex_rd, mem_rd;
    logic          id_use_rs, id_use_rt, id_branch, id_bj_taken;
    logic          id_mdu_start, id_mdu_read;
    logic          ex_memread, ex_regwrite, mem_memread, imem_ready;
    logic          pc_we, ifid_hold, ifid_flush, idex_bubble, mdu_start, mdu_busy;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_busy_rem = 0;
    int m_stall    = 0;
    int m_flush    = 0;
    int e_stall, e_redirect, e_start;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MDU_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_branch(id_branch), .id_bj_taken(id_bj_taken),
        .id_mdu_start(id_mdu_start), .id_mdu_read(id_mdu_read),
        .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
        .mem_memread(mem_memread), .mem_rd(mem_rd),
        .imem_ready(imem_ready),
        .pc_we(pc_we), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .mdu_start(mdu_start), .mdu_busy(mdu_busy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        id_rs = 0; id_rt = 0; ex_rd = 0; mem_rd = 0;
        id_use_rs = 0; id_use_rt = 0; id_branch = 0; id_bj_taken = 0;
        id_mdu_start = 0; id_mdu_read = 0;
        ex_memread = 0; ex_regwrite = 0; mem_memread = 0; imem_ready = 1;
    endtask

    // Predict and compare all outputs for the current inputs.
    task automatic model_check();
        int lu, bd, md, rs_hit_ex, rt_hit_ex;
        int e_pc, e_hold, e_fl, e_bub;
        if (rst) begin
            m_busy_rem = 0; m_stall = 0; m_flush = 0;
        end
        rs_hit_ex = (ex_rd != 0) && (id_rs == ex_rd);
        rt_hit_ex = (ex_rd != 0) && (id_rt == ex_rd);
        lu = ex_memread && ((id_use_rs && rs_hit_ex) || (id_use_rt && rt_hit_ex));
        bd = id_branch && ((ex_regwrite && (rs_hit_ex || rt_hit_ex)) ||
                           (mem_memread && mem_rd != 0 && (id_rs == mem_rd || id_rt == mem_rd)));
        md = (m_busy_rem > 0) && (id_mdu_start || id_mdu_read);
        e_stall    = lu || bd || md;
        e_redirect = !rst && !e_stall && id_bj_taken;
        e_start    = !rst && !e_stall && id_mdu_start;
        if (rst)              begin e_pc = 0; e_hold = 0; e_fl = 1; e_bub = 1; end
        else if (e_stall)     begin e_pc = 0; e_hold = 1; e_fl = 0; e_bub = 1; end
        else if (id_bj_taken) begin e_pc = 1; e_hold = 0; e_fl = 1; e_bub = 0; end
        else if (!imem_ready) begin e_pc = 0; e_hold = 0; e_fl = 1; e_bub = 0; end
        else                  begin e_pc = 1; e_hold = 0; e_fl = 0; e_bub = 0; end
        chk("pc_we", 32'(pc_we), 32'(e_pc));
        chk("ifid_hold", 32'(ifid_hold), 32'(e_hold));
        chk("ifid_flush", 32'(ifid_flush), 32'(e_fl));
        chk("idex_bubble", 32'(idex_bubble), 32'(e_bub));
        chk("mdu_start", 32'(mdu_start), 32'(e_start));
        chk("mdu_busy", 32'(mdu_busy), 32'(m_busy_rem > 0));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    endtask

    task automatic model_update();
        if (!rst) begin
            if (e_stall && m_stall < CMAX) m_stall++;
            if (e_redirect && m_flush < CMAX) m_flush++;
            if (m_busy_rem > 0) m_busy_rem--;
            else if (e_start != 0) m_busy_rem = LAT;
        end
    endtask

    // One clock: check at the falling edge, advance model at the rising edge,
    // return 1 time unit after the rising edge ready for new inputs.
    task automatic cycle();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1; idle_inputs();
        cycle();
        rst = 0;
    endtask

    int stalls;

    initial begin
        rst = 1; idle_inputs();
        #1;
        chk("reset_busy", 32'(mdu_busy), 0);
        chk("reset_stall_cnt", 32'(stall_cnt), 0);
        cycle(); cycle();
        rst = 0;

        // Load-use hazard, then the same with ex_rd = 0.
        ex_memread = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1;
        #1;
        chk("lu_hold", 32'(ifid_hold), 1);
        cycle();
        chk("lu_cnt", 32'(stall_cnt), 1);
        ex_rd = 0; id_rs = 0;
        #1;
        chk("lu_r0_pc_we", 32'(pc_we), 1);
        cycle();
        idle_inputs();

        // Branch operand dependency blocks the taken branch, then it redirects.
        do_reset();
        id_branch = 1; id_bj_taken = 1; ex_regwrite = 1; ex_rd = 8; id_rt = 8; id_rs = 3;
        #1;
        chk("brdep_flush", 32'(ifid_flush), 0);
        chk("brdep_pc_we", 32'(pc_we), 0);
        cycle();
        ex_regwrite = 0;
        #1;
        chk("br_taken_flush", 32'(ifid_flush), 1);
        cycle();
        chk("br_flush_cnt", 32'(flush_cnt), 1);
        idle_inputs();

        // Instruction-memory wait, with a taken branch during the wait.
        imem_ready = 0;
        for (int i = 0; i < 3; i++) cycle();
        id_bj_taken = 1;
        #1;
        chk("wait_bj_pc_we", 32'(pc_we), 1);
        chk("wait_bj_flush", 32'(ifid_flush), 1);
        cycle();
        idle_inputs();

        // MDU: mult then dependent mflo.
        do_reset();
        id_mdu_start = 1;
        #1;
        chk("mdu_start_pulse", 32'(mdu_start), 1);
        cycle();
        id_mdu_start = 0; id_mdu_read = 1;
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            if (pc_we) break;
            stalls++;
            cycle();
        end
        chk("mflo_stall_cycles", 32'(stalls), LAT);
        chk("mflo_stall_cnt", 32'(stall_cnt), LAT);
        chk("mflo_issue_busy", 32'(mdu_busy), 0);
        cycle();
        idle_inputs();

        // Reset in the middle of an MDU operation.
        id_mdu_start = 1;
        cycle();
        id_mdu_start = 0;
        cycle();
        rst = 1;
        #1;
        chk("rst_mid_busy", 32'(mdu_busy), 0);
        chk("rst_mid_cnt", 32'(stall_cnt), 0);
        chk("rst_mid_pc_we", 32'(pc_we), 0);
        chk("rst_mid_flush", 32'(ifid_flush), 1);
        cycle();
        rst = 0; id_mdu_start = 1;
        #1;
        chk("restart_pulse", 32'(mdu_start), 1);
        cycle();
        id_mdu_start = 0;
        #1;
        chk("restart_busy", 32'(mdu_busy), 1);
        cycle();

        // Counter saturation under a long load-use hazard.
        do_reset();
        ex_memread = 1; ex_rd = 9; id_rt = 9; id_use_rt = 1;
        for (int i = 0; i < 20; i++) cycle();
        chk("stall_sat", 32'(stall_cnt), CMAX);
        idle_inputs();

        // Randomized traffic; small register range to make hazards frequent.
        for (int n = 0; n < 2000; n++) begin
            rst          = ($urandom_range(0, 99) == 0);
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            mem_rd       = 5'($urandom_range(0, 3));
            id_use_rs    = 1'($urandom);
            id_use_rt    = 1'($urandom);
            id_branch    = ($urandom_range(0, 3) == 0);
            id_bj_taken  = ($urandom_range(0, 3) == 0);
            id_mdu_start = ($urandom_range(0, 5) == 0);
            id_mdu_read  = ($urandom_range(0, 5) == 0);
            ex_memread   = ($urandom_range(0, 3) == 0);
            ex_regwrite  = 1'($urandom);
            mem_memread  = ($urandom_range(0, 3) == 0);
            imem_ready   = ($urandom_range(0, 4) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
